// File: rtl/dig_ct_pkg.sv
// Shared limits, counter width and parameter helpers for the dig_ct_pipe slice.
package dig_ct_pkg;

  localparam int unsigned DEPTH_MAX = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned NIN_MAX   = 6;
  localparam int unsigned NCH_MAX   = 8;

  // True when every pipe parameter lies inside its legal range.
  function automatic bit params_ok(input int unsigned nin,
                                   input int unsigned nch,
                                   input int unsigned depth);
    return (nin >= 1) && (nin <= NIN_MAX) &&
           (nch >= 1) && (nch <= NCH_MAX) &&
           (depth >= 1) && (depth <= DEPTH_MAX);
  endfunction

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int unsigned sel_w(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/dig_ct_pipe_if.sv
// Operand, table-config and result bundle of dig_ct_pipe.
interface dig_ct_pipe_if
  import dig_ct_pkg::*;
#(
  parameter int unsigned NIN = 5,
  parameter int unsigned NCH = 3
);

  localparam int unsigned TBL_W = 2 ** NIN;
  localparam int unsigned SEL_W = sel_w(NCH);

  logic [NIN-1:0]   IN;
  logic             IN_VALID;
  logic             CFG_WE;
  logic [SEL_W-1:0] CFG_SEL;
  logic [TBL_W-1:0] CFG_DATA;
  logic             CNT_CLR;
  logic [NCH-1:0]   OUT;
  logic             OUT_VALID;
  logic [CNT_W-1:0] OUT_CNT;

  modport master (
    output IN, IN_VALID, CFG_WE, CFG_SEL, CFG_DATA, CNT_CLR,
    input  OUT, OUT_VALID, OUT_CNT
  );

  modport slave (
    input  IN, IN_VALID, CFG_WE, CFG_SEL, CFG_DATA, CNT_CLR,
    output OUT, OUT_VALID, OUT_CNT
  );

endinterface

// File: rtl/dig_ct_stage.sv
// One pipe stage: valid always shifts, data loads only with an incoming valid.
module dig_ct_stage #(
  parameter int unsigned W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         src_valid,
  input  logic [W-1:0] src_data,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= src_valid;
      if (src_valid) begin
        data <= src_data;
      end
    end
  end

endmodule

// File: rtl/dig_ct_pipe.sv
// Per-channel truth-table lookup followed by a DEPTH-stage result pipe and a saturating result counter.
module dig_ct_pipe
  import dig_ct_pkg::*;
#(
  parameter int unsigned NIN   = 5,
  parameter int unsigned NCH   = 3,
  parameter int unsigned DEPTH = 1
) (
  input  logic        CLK,
  input  logic        RST,
  dig_ct_pipe_if.slave bus
);

  localparam int unsigned TBL_W = 2 ** NIN;
  localparam int unsigned SEL_W = sel_w(NCH);

  if (!params_ok(NIN, NCH, DEPTH)) begin : g_param_err
    $error("dig_ct_pipe: NIN/NCH/DEPTH outside legal range");
  end

  logic [TBL_W-1:0] lut_q [NCH];
  logic [NCH-1:0]   lut_c;
  logic [DEPTH:0]   vld;
  logic [NCH-1:0]   dat [DEPTH+1];
  logic [CNT_W-1:0] cnt_q;

  // Table write; a select with no matching channel leaves every table untouched.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int c = 0; c < NCH; c++) begin
        lut_q[c] <= '0;
      end
    end else if (bus.CFG_WE) begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.CFG_SEL == SEL_W'(c)) begin
          lut_q[c] <= bus.CFG_DATA;
        end
      end
    end
  end

  // Lookup reads the pre-write table, so a same-edge write affects only later samples.
  always_comb begin
    lut_c = '0;
    for (int c = 0; c < NCH; c++) begin
      lut_c[c] = lut_q[c][bus.IN];
    end
  end

  assign vld[0] = bus.IN_VALID;
  assign dat[0] = lut_c;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dig_ct_stage #(
      .W (NCH)
    ) u_stage (
      .CLK       (CLK),
      .RST       (RST),
      .src_valid (vld[i]),
      .src_data  (dat[i]),
      .valid     (vld[i+1]),
      .data      (dat[i+1])
    );
  end

  // Counts cycles spent with OUT_VALID high; clear has priority over the increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (bus.CNT_CLR) begin
      cnt_q <= '0;
    end else if (vld[DEPTH] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.OUT       = dat[DEPTH];
  assign bus.OUT_VALID = vld[DEPTH];
  assign bus.OUT_CNT   = cnt_q;

endmodule

// File: tb/tb_dig_ct_pipe.sv
// Directed bench for dig_ct_pipe at DEPTH 1, 2 and 4 sharing one stimulus stream.
module tb_dig_ct_pipe;

  logic        CLK;
  logic        RST;
  logic [4:0]  in_d;
  logic        in_valid;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_data;
  logic        cnt_clr;

  int n_chk;
  int n_fail;

  dig_ct_pipe_if #(.NIN(5), .NCH(3)) if1 ();
  dig_ct_pipe_if #(.NIN(5), .NCH(3)) if2 ();
  dig_ct_pipe_if #(.NIN(5), .NCH(3)) if4 ();

  assign if1.IN = in_d;       assign if2.IN = in_d;       assign if4.IN = in_d;
  assign if1.IN_VALID = in_valid; assign if2.IN_VALID = in_valid; assign if4.IN_VALID = in_valid;
  assign if1.CFG_WE = cfg_we;     assign if2.CFG_WE = cfg_we;     assign if4.CFG_WE = cfg_we;
  assign if1.CFG_SEL = cfg_sel;   assign if2.CFG_SEL = cfg_sel;   assign if4.CFG_SEL = cfg_sel;
  assign if1.CFG_DATA = cfg_data; assign if2.CFG_DATA = cfg_data; assign if4.CFG_DATA = cfg_data;
  assign if1.CNT_CLR = cnt_clr;   assign if2.CNT_CLR = cnt_clr;   assign if4.CNT_CLR = cnt_clr;

  dig_ct_pipe #(.NIN(5), .NCH(3), .DEPTH(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(if1));
  dig_ct_pipe #(.NIN(5), .NCH(3), .DEPTH(2)) u_dut2 (.CLK(CLK), .RST(RST), .bus(if2));
  dig_ct_pipe #(.NIN(5), .NCH(3), .DEPTH(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(if4));

  logic [2:0]  o_out [3];
  logic        o_vld [3];
  logic [15:0] o_cnt [3];
  assign o_out[0] = if1.OUT; assign o_vld[0] = if1.OUT_VALID; assign o_cnt[0] = if1.OUT_CNT;
  assign o_out[1] = if2.OUT; assign o_vld[1] = if2.OUT_VALID; assign o_cnt[1] = if2.OUT_CNT;
  assign o_out[2] = if4.OUT; assign o_vld[2] = if4.OUT_VALID; assign o_cnt[2] = if4.OUT_CNT;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int          lat [3];
    logic [4:0]  vec [3];
    logic [2:0]  exp_out [3];
    int          idx;
    logic        exp_v;
    logic [2:0]  exp_o;

    lat[0] = 1; lat[1] = 2; lat[2] = 4;
    vec[0] = 5'h00; vec[1] = 5'h1F; vec[2] = 5'h01;
    // {LUT2[k], LUT1[k], LUT0[k]} for k = 0x00, 0x1F, 0x01
    exp_out[0] = 3'b010; exp_out[1] = 3'b101; exp_out[2] = 3'b110;

    n_chk = 0;
    n_fail = 0;

    // Reset held with a valid sample on the inputs.
    RST = 1'b0; in_d = 5'h1F; in_valid = 1'b1;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 32'h0; cnt_clr = 1'b0;
    repeat (3) step();
    chk("rst_out", 32'(if2.OUT), 32'(3'b000));
    chk("rst_vld", 32'(if2.OUT_VALID), 32'(1'b0));
    chk("rst_cnt", 32'(if2.OUT_CNT), 32'(16'd0));

    // First sample at the first edge with reset released, tables still zero.
    RST = 1'b1;
    step();
    in_valid = 1'b0;
    chk("d1_first_vld", 32'(if1.OUT_VALID), 32'(1'b1));
    chk("d1_first_out", 32'(if1.OUT), 32'(3'b000));
    chk("d2_early_vld", 32'(if2.OUT_VALID), 32'(1'b0));
    step();
    chk("d2_first_vld", 32'(if2.OUT_VALID), 32'(1'b1));
    chk("d2_first_out", 32'(if2.OUT), 32'(3'b000));
    step();
    chk("d2_after_vld", 32'(if2.OUT_VALID), 32'(1'b0));
    chk("d2_first_cnt", 32'(if2.OUT_CNT), 32'(16'd1));
    step();
    chk("d4_first_vld", 32'(if4.OUT_VALID), 32'(1'b1));
    step();
    chk("d4_first_cnt", 32'(if4.OUT_CNT), 32'(16'd1));

    // Load all three tables.
    cfg_we = 1'b1;
    cfg_sel = 2'd0; cfg_data = 32'hFFFF_FFF0; step();
    cfg_sel = 2'd1; cfg_data = 32'h7FFF_FFFF; step();
    cfg_sel = 2'd2; cfg_data = 32'hAAAA_AAAA; step();
    cfg_we = 1'b0;
    step();

    // Back-to-back samples, then a gap; each depth checked at its own latency.
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = (cyc < 3);
      if (cyc < 3) in_d = vec[cyc];
      else         in_d = 5'h00;
      step();
      for (int d = 0; d < 3; d++) begin
        idx = cyc - (lat[d] - 1);
        exp_v = (idx >= 0) && (idx < 3);
        if (idx < 0)      exp_o = 3'b000;
        else if (idx > 2) exp_o = exp_out[2];
        else              exp_o = exp_out[idx];
        chk($sformatf("stream_vld_d%0d_c%0d", lat[d], cyc), 32'(o_vld[d]), 32'(exp_v));
        chk($sformatf("stream_out_d%0d_c%0d", lat[d], cyc), 32'(o_out[d]), 32'(exp_o));
      end
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("stream_cnt_d%0d", lat[d]), 32'(o_cnt[d]), 32'(16'd4));
    end

    // Write LUT0 in the same cycle as a sample, then restore it with the next sample in flight.
    in_d = 5'h00; in_valid = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'h0000_000F;
    step();
    cfg_data = 32'hFFFF_FFF0;
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    chk("wr_old_vld", 32'(if2.OUT_VALID), 32'(1'b1));
    chk("wr_old_out", 32'(if2.OUT), 32'(3'b010));
    step();
    chk("wr_new_vld", 32'(if2.OUT_VALID), 32'(1'b1));
    chk("wr_new_out", 32'(if2.OUT), 32'(3'b011));
    step();
    chk("hold_vld", 32'(if2.OUT_VALID), 32'(1'b0));
    chk("hold_out", 32'(if2.OUT), 32'(3'b011));

    // Out-of-range select must not touch any table.
    cfg_we = 1'b1; cfg_sel = 2'd3; cfg_data = 32'hFFFF_FFFF;
    step();
    cfg_we = 1'b0; in_d = 5'h00; in_valid = 1'b1;
    step();
    in_d = 5'h1F;
    step();
    in_valid = 1'b0;
    chk("sel3_out_00", 32'(if2.OUT), 32'(3'b010));
    step();
    chk("sel3_out_1f", 32'(if2.OUT), 32'(3'b101));

    // Asynchronous reset with results in flight.
    in_d = 5'h00; in_valid = 1'b1;
    step();
    in_d = 5'h1F;
    step();
    in_valid = 1'b0;
    chk("pre_rst_vld", 32'(if2.OUT_VALID), 32'(1'b1));
    #2 RST = 1'b0;
    #1;
    chk("arst_out", 32'(if2.OUT), 32'(3'b000));
    chk("arst_vld", 32'(if2.OUT_VALID), 32'(1'b0));
    chk("arst_cnt", 32'(if2.OUT_CNT), 32'(16'd0));
    chk("arst_vld_d4", 32'(if4.OUT_VALID), 32'(1'b0));
    step();
    step();
    RST = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("post_rst_vld_d%0d_c%0d", lat[d], k), 32'(o_vld[d]), 32'(1'b0));
      end
    end

    // Counter saturation and clear-over-increment.
    in_d = 5'h00; in_valid = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      step();
    end
    chk("sat_preload", 32'(if2.OUT_CNT), 32'(16'd65534));
    step();
    in_valid = 1'b0;
    chk("sat_first_vld", 32'(if2.OUT_VALID), 32'(1'b1));
    chk("sat_first", 32'(if2.OUT_CNT), 32'(16'hFFFF));
    step();
    chk("sat_hold_vld", 32'(if2.OUT_VALID), 32'(1'b1));
    chk("sat_hold", 32'(if2.OUT_CNT), 32'(16'hFFFF));
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_wins", 32'(if2.OUT_CNT), 32'(16'd0));
    chk("clr_vld", 32'(if2.OUT_VALID), 32'(1'b0));
    step();
    chk("clr_stays", 32'(if2.OUT_CNT), 32'(16'd0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
